// File: rtl/issue_select_n_pkg.sv
// Shared types for the scoreboard issue stage: FU slot states and age defaults.
package issue_select_n_pkg;

    typedef enum logic [1:0] {
        FUST_EMPTY = 2'd0,
        FUST_WAIT  = 2'd1,
        FUST_RDY   = 2'd2,
        FUST_EX    = 2'd3
    } fust_state_e;

    localparam logic [1:0] ST_EMPTY = FUST_EMPTY;
    localparam logic [1:0] ST_WAIT  = FUST_WAIT;
    localparam logic [1:0] ST_RDY   = FUST_RDY;
    localparam logic [1:0] ST_EX    = FUST_EX;

    localparam int         ISSUE_AGE_W_DEF = 6;
    localparam logic [5:0] ISSUE_AGE_MAX   = 6'd63;

endpackage

// File: rtl/issue_select_n_if.sv
// Dispatch/FUST-facing bundle of the issue-select core; master drives, slave is the core.
interface issue_select_if #(
    parameter int NUM_FU = 5,
    parameter int AGE_W  = 6
);
    logic                      freeze;
    logic                      branch_miss;
    logic                      branch_resolved;
    logic [NUM_FU-1:0]         alloc_en;
    logic [NUM_FU-1:0]         alloc_spec;
    logic [NUM_FU-1:0]         deps_clear;
    logic [NUM_FU-1:0]         fu_done;
    logic [NUM_FU-1:0]         alloc_ready;
    logic [NUM_FU-1:0]         issue_grant;
    logic [2*NUM_FU-1:0]       slot_state;
    logic [NUM_FU-1:0]         slot_busy;
    logic [AGE_W*NUM_FU-1:0]   slot_age;

    modport master (
        output freeze, branch_miss, branch_resolved,
               alloc_en, alloc_spec, deps_clear, fu_done,
        input  alloc_ready, issue_grant, slot_state, slot_busy, slot_age
    );

    modport slave (
        input  freeze, branch_miss, branch_resolved,
               alloc_en, alloc_spec, deps_clear, fu_done,
        output alloc_ready, issue_grant, slot_state, slot_busy, slot_age
    );

endinterface

// File: rtl/issue_select_n_pick.sv
// Combinational oldest-first picker: one-hot of the masked slot with the highest age.
module age_oldest_pick
    import issue_select_n_pkg::*;
#(
    parameter int NUM_FU = 5,
    parameter int AGE_W  = ISSUE_AGE_W_DEF
) (
    input  logic [NUM_FU-1:0]       mask,
    input  logic [AGE_W*NUM_FU-1:0] ages,
    output logic [NUM_FU-1:0]       pick
);

    logic [AGE_W-1:0] best_age;
    logic             found;

    // Strict compare while scanning upward keeps the lower index on equal ages.
    always_comb begin
        pick     = '0;
        best_age = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (mask[i] && (!found || ages[i*AGE_W +: AGE_W] > best_age)) begin
                pick     = '0;
                pick[i]  = 1'b1;
                best_age = ages[i*AGE_W +: AGE_W];
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_select_n.sv
// Issue-selection core: tracks FU slots EMPTY/WAIT/RDY/EX, ages them and grants the oldest ready.
module issue_select_n
    import issue_select_n_pkg::*;
#(
    parameter int                NUM_FU  = 5,
    parameter int                ISSUE_W = 1,
    parameter int                AGE_W   = ISSUE_AGE_W_DEF,
    parameter logic [NUM_FU-1:0] SPEC_OK = NUM_FU'(1)
) (
    input  logic          CLK,
    input  logic          nRST,
    issue_select_if.slave bus
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic                    alloc_ok;
    logic                    any_alloc;
    logic [NUM_FU-1:0]       alloc_rdy;
    logic [NUM_FU-1:0]       alloc_acc;
    logic [NUM_FU-1:0]       cand;
    logic [NUM_FU-1:0]       grant;
    logic [NUM_FU-1:0]       busy;
    logic [2*NUM_FU-1:0]     state_flat;
    logic [AGE_W*NUM_FU-1:0] age_flat;

    assign alloc_ok  = !bus.freeze && !bus.branch_miss;
    assign alloc_acc = bus.alloc_en & alloc_rdy;
    assign any_alloc = |alloc_acc;

    for (genvar i = 0; i < NUM_FU; i++) begin : slot_g
        logic [1:0]       st_q;
        logic [AGE_W-1:0] age_q;
        logic             spec_q;

        assign alloc_rdy[i] = alloc_ok &&
                              (st_q == ST_EMPTY || (st_q == ST_EX && bus.fu_done[i]));
        assign cand[i]      = (st_q == ST_RDY || (st_q == ST_WAIT && bus.deps_clear[i])) &&
                              alloc_ok && (!spec_q || SPEC_OK[i] || bus.branch_resolved);
        assign busy[i]      = (st_q != ST_EMPTY);
        assign state_flat[2*i +: 2]       = st_q;
        assign age_flat[i*AGE_W +: AGE_W] = age_q;

        // A miss flush outranks alloc (alloc_ok is low then) and resolve.
        always_ff @(posedge CLK) begin
            if (!nRST) begin
                st_q   <= ST_EMPTY;
                age_q  <= '0;
                spec_q <= 1'b0;
            end else if (bus.branch_miss && spec_q) begin
                st_q   <= ST_EMPTY;
                age_q  <= '0;
                spec_q <= 1'b0;
            end else if (alloc_acc[i]) begin
                st_q   <= ST_WAIT;
                age_q  <= AGE_W'(1);
                spec_q <= bus.alloc_spec[i];
            end else begin
                if (bus.branch_resolved) begin
                    spec_q <= 1'b0;
                end
                case (st_q)
                    ST_WAIT, ST_RDY: begin
                        if (grant[i]) begin
                            st_q  <= ST_EX;
                            age_q <= '0;
                        end else begin
                            if (st_q == ST_WAIT && bus.deps_clear[i] && alloc_ok) begin
                                st_q <= ST_RDY;
                            end
                            if (any_alloc && age_q != AGE_MAX) begin
                                age_q <= age_q + AGE_W'(1);
                            end
                        end
                    end
                    ST_EX: begin
                        if (bus.fu_done[i]) begin
                            st_q <= ST_EMPTY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pickers cascade: each stage only sees candidates the earlier stages skipped.
    logic [NUM_FU-1:0] pick_mask [ISSUE_W];
    logic [NUM_FU-1:0] pick      [ISSUE_W];

    for (genvar k = 0; k < ISSUE_W; k++) begin : pick_g
        if (k == 0) begin : first_g
            assign pick_mask[k] = cand;
        end else begin : next_g
            assign pick_mask[k] = pick_mask[k-1] & ~pick[k-1];
        end

        age_oldest_pick #(
            .NUM_FU (NUM_FU),
            .AGE_W  (AGE_W)
        ) u_pick (
            .mask (pick_mask[k]),
            .ages (age_flat),
            .pick (pick[k])
        );
    end

    always_comb begin
        grant = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            grant = grant | pick[k];
        end
    end

    assign bus.alloc_ready = alloc_rdy;
    assign bus.issue_grant = grant;
    assign bus.slot_state  = state_flat;
    assign bus.slot_busy   = busy;
    assign bus.slot_age    = age_flat;

endmodule
